// File: rtl/jbi_min_wdq_ctl.sv
// Pointer, occupancy and flow-control logic for the 16 x 160-bit JBI write
// decomposition queue; turns beat-level push/pop into buffer enables/addresses.
module jbi_min_wdq_ctl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned HWM        = 12
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  push,
  input  logic                  push_last,
  input  logic                  pop,
  input  logic                  err_clr,
  output logic                  wdq_wr_en,
  output logic [ADDR_WIDTH-1:0] wdq_waddr,
  output logic                  wdq_rd_en,
  output logic [ADDR_WIDTH-1:0] wdq_raddr,
  output logic                  rdata_vld,
  output logic                  rdata_last,
  output logic                  wdq_full,
  output logic                  wdq_empty,
  output logic [ADDR_WIDTH:0]   wdq_level,
  output logic                  txn_avail,
  output logic                  throttle,
  output logic                  ovf_err,
  output logic                  unf_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;
  localparam int unsigned TW    = 5;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [LW-1:0]         level;
  logic [LW-1:0]         level_nxt;
  logic [DEPTH-1:0]      last_flag;
  logic [TW-1:0]         txn_cnt;
  logic [TW-1:0]         txn_nxt;
  logic                  rdata_vld_q;
  logic                  rdata_last_q;
  logic                  throttle_q;
  logic                  ovf_err_q;
  logic                  unf_err_q;
  logic                  full_c;
  logic                  empty_c;
  logic                  txn_inc_c;
  logic                  txn_dec_c;

  // Status decoded straight from the registered occupancy.
  assign full_c     = (level == LW'(DEPTH));
  assign empty_c    = (level == LW'(0));

  assign wdq_wr_en  = push & ~full_c;
  assign wdq_rd_en  = pop & ~empty_c;
  assign wdq_waddr  = wptr;
  assign wdq_raddr  = rptr;
  assign wdq_full   = full_c;
  assign wdq_empty  = empty_c;
  assign wdq_level  = level;
  assign txn_avail  = (txn_cnt != TW'(0));
  assign rdata_vld  = rdata_vld_q;
  assign rdata_last = rdata_last_q;
  assign throttle   = throttle_q;
  assign ovf_err    = ovf_err_q;
  assign unf_err    = unf_err_q;

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    level_nxt = level;
    if (wdq_wr_en && !wdq_rd_en) begin
      level_nxt = level + LW'(1);
    end else if (!wdq_wr_en && wdq_rd_en) begin
      level_nxt = level - LW'(1);
    end
  end

  // Completed-transaction count: a flagged beat in adds one, a flagged beat out removes one.
  always_comb begin
    txn_inc_c = wdq_wr_en & push_last;
    txn_dec_c = wdq_rd_en & last_flag[rptr];
    txn_nxt   = txn_cnt;
    if (txn_inc_c && !txn_dec_c) begin
      txn_nxt = txn_cnt + TW'(1);
    end else if (!txn_inc_c && txn_dec_c) begin
      txn_nxt = txn_cnt - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      last_flag    <= '0;
      txn_cnt      <= '0;
      rdata_vld_q  <= 1'b0;
      rdata_last_q <= 1'b0;
      throttle_q   <= 1'b0;
      ovf_err_q    <= 1'b0;
      unf_err_q    <= 1'b0;
    end else begin
      if (wdq_wr_en) begin
        last_flag[wptr] <= push_last;
        wptr            <= wptr + ADDR_WIDTH'(1);
      end
      if (wdq_rd_en) begin
        rptr         <= rptr + ADDR_WIDTH'(1);
        rdata_last_q <= last_flag[rptr];
      end else begin
        rdata_last_q <= 1'b0;
      end
      rdata_vld_q <= wdq_rd_en;
      level       <= level_nxt;
      txn_cnt     <= txn_nxt;
      throttle_q  <= (level_nxt >= LW'(HWM));
      // A new error in the same cycle as err_clr keeps the flag set.
      ovf_err_q   <= (push & full_c) | (ovf_err_q & ~err_clr);
      unf_err_q   <= (pop & empty_c) | (unf_err_q & ~err_clr);
    end
  end

endmodule

// File: tb/tb_jbi_min_wdq_ctl.sv
// Directed bench for jbi_min_wdq_ctl: a vector table for the basic flow plus
// hand-written sequences for fill/overflow, simultaneous ops, wrap and reset.
module tb_jbi_min_wdq_ctl;

  logic       clk;
  logic       rst_l;
  logic       push;
  logic       push_last;
  logic       pop;
  logic       err_clr;
  logic       wdq_wr_en;
  logic [3:0] wdq_waddr;
  logic       wdq_rd_en;
  logic [3:0] wdq_raddr;
  logic       rdata_vld;
  logic       rdata_last;
  logic       wdq_full;
  logic       wdq_empty;
  logic [4:0] wdq_level;
  logic       txn_avail;
  logic       throttle;
  logic       ovf_err;
  logic       unf_err;

  int n_total;
  int n_pass;

  jbi_min_wdq_ctl #(.ADDR_WIDTH(4), .HWM(12)) dut (
    .clk(clk), .rst_l(rst_l), .push(push), .push_last(push_last), .pop(pop),
    .err_clr(err_clr), .wdq_wr_en(wdq_wr_en), .wdq_waddr(wdq_waddr),
    .wdq_rd_en(wdq_rd_en), .wdq_raddr(wdq_raddr), .rdata_vld(rdata_vld),
    .rdata_last(rdata_last), .wdq_full(wdq_full), .wdq_empty(wdq_empty),
    .wdq_level(wdq_level), .txn_avail(txn_avail), .throttle(throttle),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit rst_l, push, last, pop, clr;
    bit wr_en; int waddr; bit rd_en; int raddr;
    int level; bit vld, rlast, txn, thr, ovf, unf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change on the falling edge so they are stable at the rising edge.
  task automatic drive(input bit r, input bit p, input bit l, input bit q, input bit c);
    @(negedge clk);
    rst_l = r; push = p; push_last = l; pop = q; err_clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic bit pat(input int k);
    return ((k * 5) % 7) < 2;
  endfunction

  vec_t tbl[$];

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_l = 1'b0; push = 1'b0; push_last = 1'b0; pop = 1'b0; err_clr = 1'b0;

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rst_level", int'(wdq_level), 0);
    chk("rst_empty", int'(wdq_empty), 1);
    chk("rst_full", int'(wdq_full), 0);
    chk("rst_txn", int'(txn_avail), 0);
    chk("rst_thr", int'(throttle), 0);
    chk("rst_vld", int'(rdata_vld), 0);
    chk("rst_rlast", int'(rdata_last), 0);
    chk("rst_ovf", int'(ovf_err), 0);
    chk("rst_unf", int'(unf_err), 0);
    chk("rst_waddr", int'(wdq_waddr), 0);
    chk("rst_raddr", int'(wdq_raddr), 0);

    // rst push last pop clr | wr waddr rd raddr | level vld rlast txn thr ovf unf
    tbl.push_back(vec_t'{1,1,0,0,0, 1,0,0,0, 1,0,0,0,0,0,0});
    tbl.push_back(vec_t'{1,1,0,0,0, 1,1,0,0, 2,0,0,0,0,0,0});
    tbl.push_back(vec_t'{1,1,0,0,0, 1,2,0,0, 3,0,0,0,0,0,0});
    tbl.push_back(vec_t'{1,1,1,0,0, 1,3,0,0, 4,0,0,1,0,0,0});
    tbl.push_back(vec_t'{1,0,0,1,0, 0,4,1,0, 3,1,0,1,0,0,0});
    tbl.push_back(vec_t'{1,0,0,1,0, 0,4,1,1, 2,1,0,1,0,0,0});
    tbl.push_back(vec_t'{1,0,0,1,0, 0,4,1,2, 1,1,0,1,0,0,0});
    tbl.push_back(vec_t'{1,0,0,1,0, 0,4,1,3, 0,1,1,0,0,0,0});
    tbl.push_back(vec_t'{1,0,0,0,0, 0,4,0,4, 0,0,0,0,0,0,0});
    tbl.push_back(vec_t'{1,0,0,1,0, 0,4,0,4, 0,0,0,0,0,0,1});
    tbl.push_back(vec_t'{1,0,0,0,1, 0,4,0,4, 0,0,0,0,0,0,0});
    tbl.push_back(vec_t'{1,1,0,1,0, 1,4,0,4, 1,0,0,0,0,0,1});
    tbl.push_back(vec_t'{1,0,0,0,1, 0,5,0,4, 1,0,0,0,0,0,0});
    tbl.push_back(vec_t'{0,1,0,1,0, 1,5,1,4, 0,0,0,0,0,0,0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_l, tbl[i].push, tbl[i].last, tbl[i].pop, tbl[i].clr);
      chk($sformatf("v%0d_wr_en", i), int'(wdq_wr_en), int'(tbl[i].wr_en));
      chk($sformatf("v%0d_waddr", i), int'(wdq_waddr), tbl[i].waddr);
      chk($sformatf("v%0d_rd_en", i), int'(wdq_rd_en), int'(tbl[i].rd_en));
      chk($sformatf("v%0d_raddr", i), int'(wdq_raddr), tbl[i].raddr);
      tick();
      chk($sformatf("v%0d_level", i), int'(wdq_level), tbl[i].level);
      chk($sformatf("v%0d_empty", i), int'(wdq_empty), int'(tbl[i].level == 0));
      chk($sformatf("v%0d_vld", i), int'(rdata_vld), int'(tbl[i].vld));
      chk($sformatf("v%0d_rlast", i), int'(rdata_last), int'(tbl[i].rlast));
      chk($sformatf("v%0d_txn", i), int'(txn_avail), int'(tbl[i].txn));
      chk($sformatf("v%0d_thr", i), int'(throttle), int'(tbl[i].thr));
      chk($sformatf("v%0d_ovf", i), int'(ovf_err), int'(tbl[i].ovf));
      chk($sformatf("v%0d_unf", i), int'(unf_err), int'(tbl[i].unf));
    end

    // Fill to 16, then overflow, clear, and simultaneous push/pop at full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'((i % 4) == 3), 1'b0, 1'b0);
      chk($sformatf("fill%0d_waddr", i), int'(wdq_waddr), i);
      tick();
      chk($sformatf("fill%0d_level", i), int'(wdq_level), i + 1);
      chk($sformatf("fill%0d_thr", i), int'(throttle), int'(i + 1 >= 12));
      chk($sformatf("fill%0d_full", i), int'(wdq_full), int'(i == 15));
    end
    chk("fill_txn", int'(txn_avail), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_wr_en", int'(wdq_wr_en), 0);
    tick();
    chk("ovf_err", int'(ovf_err), 1);
    chk("ovf_level", int'(wdq_level), 16);
    chk("ovf_waddr", int'(wdq_waddr), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ovf_clr", int'(ovf_err), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("full_pp_wr_en", int'(wdq_wr_en), 0);
    chk("full_pp_rd_en", int'(wdq_rd_en), 1);
    tick();
    chk("full_pp_level", int'(wdq_level), 15);
    chk("full_pp_ovf", int'(ovf_err), 1);
    chk("full_pp_vld", int'(rdata_vld), 1);
    chk("full_pp_rlast", int'(rdata_last), 0);
    chk("full_pp_waddr", int'(wdq_waddr), 0);
    chk("full_pp_raddr", int'(wdq_raddr), 1);
    chk("full_pp_thr", int'(throttle), 1);
    chk("full_pp_txn", int'(txn_avail), 1);

    // Error set while err_clr is asserted: error wins
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ovf_clr_race", int'(ovf_err), 1);

    // Simultaneous push and pop at level 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("l5_wr_en", int'(wdq_wr_en), 1);
    chk("l5_rd_en", int'(wdq_rd_en), 1);
    tick();
    chk("l5_level", int'(wdq_level), 5);
    chk("l5_waddr", int'(wdq_waddr), 6);
    chk("l5_raddr", int'(wdq_raddr), 1);
    chk("l5_vld", int'(rdata_vld), 1);

    // Pointer wrap: 40 push/pop pairs at steady level 3
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, pat(k), 1'b0, 1'b0);
      tick();
    end
    for (int j = 0; j < 40; j++) begin
      drive(1'b1, 1'b1, pat(j + 3), 1'b1, 1'b0);
      chk($sformatf("wrap%0d_waddr", j), int'(wdq_waddr), (j + 3) % 16);
      chk($sformatf("wrap%0d_raddr", j), int'(wdq_raddr), j % 16);
      tick();
      chk($sformatf("wrap%0d_vld", j), int'(rdata_vld), 1);
      chk($sformatf("wrap%0d_rlast", j), int'(rdata_last), int'(pat(j)));
      chk($sformatf("wrap%0d_level", j), int'(wdq_level), 3);
    end

    // Reset mid-operation with level 7, two complete transactions, pop in flight
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'(i == 1 || i == 4), 1'b0, 1'b0);
      tick();
    end
    chk("mid_pre_level", int'(wdq_level), 7);
    chk("mid_pre_txn", int'(txn_avail), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mid_rd_en", int'(wdq_rd_en), 1);
    tick();
    chk("mid_vld", int'(rdata_vld), 0);
    chk("mid_level", int'(wdq_level), 0);
    chk("mid_empty", int'(wdq_empty), 1);
    chk("mid_txn", int'(txn_avail), 0);
    chk("mid_waddr", int'(wdq_waddr), 0);
    chk("mid_raddr", int'(wdq_raddr), 0);
    chk("mid_unf", int'(unf_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
